ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED LED-set or 0xFF reset, over the same open-drain ps2_clk/ps2_data pair that the receive path listens on. It implements the full host request: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, then a check for the device acknowledge. It sits beside the PS/2 receiver in the keyboard subsystem. While it is busy, the receiver's output is ignored by the owner.

Parameters:
INHIBIT_CYCLES, 2500, clk cycles ps2_clk is held low before the start bit (≥100 us; 2500 = 100 us at 25 MHz)
TIMEOUT_CYCLES, 375000, max clk cycles allowed between consecutive device clock falling edges, or from request to first edge (15 ms at 25 MHz)
FILT_LEN, 8, ps2_clk filter depth; a level is accepted after FILT_LEN+1 identical samples

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  1 = idle, can accept a byte
ps2_clk  in  1  raw PS/2 clock pin level
ps2_data  in  1  raw PS/2 data pin level
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
done  out  1  one-cycle pulse: byte sent and ACK received
err  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; done=0; err=0; counters cleared.
  - Both lines are released immediately, including mid-transfer.
- Input conditioning:
  - ps2_data is registered once.
  - ps2_clk goes through the filter. The filtered level goes to 1 when all FILT_LEN+1 samples are 1, and to 0 when all are 0.
  - fall = one-cycle pulse on a filtered 1→0 transition.
- Handshake:
  - The byte is latched on tx_valid && tx_ready, and tx_ready drops on the next cycle.
  - tx_valid is ignored while tx_ready=0.
- Parity: par = ~^tx_data, giving odd parity over the 9 bits.
- States:
  - IDLE: tx_ready=1, both oe=0. On accept: latch the byte, load the counter with INHIBIT_CYCLES, go to INHIBIT.
  - INHIBIT:
    - ps2_clk_oe=1.
    - ps2_data_oe=1 during the final 16 cycles of the count.
    - fall pulses are ignored.
    - When the count expires: ps2_clk_oe=0, ps2_data_oe=1 (start bit), bitcnt=0, load TIMEOUT_CYCLES, go to SEND.
  - SEND (device clocks):
    - On each fall, bitcnt increments and the timeout reloads.
    - fall 1–8: ps2_data_oe = ~data[bitcnt-1].
    - fall 9: ps2_data_oe = ~par.
    - fall 10: ps2_data_oe=0 (stop bit, line released); go to ACK.
  - ACK:
    - On the next fall, sample the registered ps2_data.
    - If it is 0, go to WAITHI.
    - Otherwise pulse err and go to IDLE.
  - WAITHI: when the filtered ps2_clk is 1 and the registered ps2_data is 1, pulse done and go to IDLE.
- Timeout:
  - Applies in SEND, ACK and WAITHI.
  - When the counter reaches 0: pulse err, release both lines, go to IDLE.
- done and err are never asserted in the same cycle.
- tx_ready returns to 1 in the same cycle as the done or err pulse.
- Counter width is $clog2 of the larger of INHIBIT_CYCLES and TIMEOUT_CYCLES.
- No fall is counted in IDLE or INHIBIT. The rise after clock release is not an edge event.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, SEND, ACK, WAITHI);
  - the PS/2 command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
- One sub-module, ps2_clk_filter (clk, rst_n, raw → level, fall), is reused by the receive path.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz:
  - ps2_clk_oe is held for ≥2500 cycles;
  - the model samples 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - the model pulls ACK low → done is one pulse, and tx_ready=1 afterwards.
- Send 0x00: parity bit is 1. Send 0xFF: parity bit is 1. Send 0x01: parity bit is 0. All transfers end with done.
- The device omits ACK (data stays high on clock 11) → err is one pulse, done never asserts, both oe=0.
- The device stops clocking after bit 4 → err fires exactly TIMEOUT_CYCLES after the 5th fall, and lines are released.
- tx_valid is held high through a transfer → exactly one byte is sent. tx_data changed mid-transfer does not alter the transmitted bits.
- rst_n is asserted during SEND → ps2_clk_oe=0 and ps2_data_oe=0 within the same cycle (asynchronously). After release, the next tx_valid starts a clean INHIBIT.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    SEND    = 3'd2,
    ACK     = 3'd3,
    WAITHI  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Number of inhibit cycles, at the end of the inhibit window, during which
  // data is already pulled low so the start bit is in place at clock release.
  localparam int DATA_LEAD_CYCLES = 16;

  // Parity bit that makes the 9-bit (data + parity) word carry an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounce for the PS/2 clock pin: a level is accepted only after FILT_LEN+1
// identical samples; fall pulses for one cycle on an accepted 1->0 change.
module ps2_clk_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [FILT_LEN:0] hist;

  // Shift in raw samples; switch the level only on a unanimous history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      hist <= {hist[FILT_LEN-1:0], raw};
      fall <= 1'b0;
      if (&hist) begin
        level <= 1'b1;
      end else if (~|hist) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data bits
// LSB-first, odd parity, stop, then device acknowledge, with a per-edge timeout.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready;
// tx_ready is 0 from the next cycle until the cycle done or err pulses, and
// tx_valid is ignored meanwhile.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  // Sized so the load value itself always fits.
  localparam int CW = $clog2(CNT_MAX + 1);

  // Counters are loaded with N-1 and expire on the cycle they read zero,
  // which gives exactly N cycles in the state.
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LEAD     = CW'(DATA_LEAD_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t       state;
  logic [CW-1:0] cnt;
  logic [3:0]   bitcnt;
  logic [7:0]   data;
  logic         data_q;
  logic         clk_level;
  logic         clk_fall;

  ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // Single register stage on the data pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= 1'b1;
    else        data_q <= ps2_data;
  end

  // Transfer sequencer with registered line enables and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      data        <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready    <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            data        <= tx_data;
            cnt         <= INH_LOAD;
            tx_ready    <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INH_LOAD < LEAD);
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            bitcnt      <= '0;
            cnt         <= TO_LOAD;
            state       <= SEND;
          end else begin
            cnt         <= cnt - ONE;
            ps2_data_oe <= (cnt <= LEAD);
          end
        end
        SEND: begin
          if (clk_fall) begin
            cnt    <= TO_LOAD;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              ps2_data_oe <= ~data[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              ps2_data_oe <= ~odd_parity(data);
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end else if (cnt == '0) begin
            err         <= 1'b1;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ACK: begin
          if (clk_fall) begin
            cnt <= TO_LOAD;
            if (!data_q) begin
              state <= WAITHI;
            end else begin
              err      <= 1'b1;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end
          end else if (cnt == '0) begin
            err         <= 1'b1;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        WAITHI: begin
          if (clk_level && data_q) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else if (cnt == '0) begin
            err         <= 1'b1;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          tx_ready    <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks the frame in,
// and each received frame is compared with one built from the byte by counting ones.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int TMO  = 1500;
  localparam int FL   = 4;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;

  // Open-drain wiring: either side pulling low wins.
  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILT_LEN      (FL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk_pin),
    .ps2_data   (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .err        (err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  // Pulse monitor
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) overlap_cnt++;
  end

  // Device-model observations
  logic [10:0] dev_frame;
  int          dev_inh;
  int          dev_inh_d;
  bit          dev_ok;

  // Reference frame: start 0, data LSB first, parity making the ones count odd, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[0]  = 1'b0;
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Driver: present one byte for one accepting edge.
  task automatic request(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: wait for the host request, then generate nfalls clock pulses,
  // sampling data at the end of each high phase; optionally ACK on pulse 11.
  task automatic device_xfer(input bit do_ack, input int nfalls);
    int w;
    dev_ok    = 1'b1;
    dev_frame = '0;
    dev_inh   = 0;
    dev_inh_d = 0;
    w = 0;
    while (!ps2_clk_oe && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!ps2_clk_oe) begin
      dev_ok = 1'b0;
      return;
    end
    while (ps2_clk_oe && dev_inh < 4 * INH) begin
      dev_inh++;
      if (ps2_data_oe) dev_inh_d++;
      @(negedge clk);
    end
    if (ps2_clk_oe) begin
      dev_ok = 1'b0;
      return;
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      if (i < 11) dev_frame[i] = ps2_data_pin;
      if (i == 10 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == 10) dev_data_low = 1'b0;
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit do_ack, output int dn, output int er);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      request(b);
      device_xfer(do_ack, 11);
    join
    repeat (10) @(negedge clk);
    dn = done_cnt - d0;
    er = err_cnt - e0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    tests_run++; if (ps2_clk_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    tests_run++; if (ps2_data_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_led_cmd();
    int d0, e0;
    logic [10:0] ef;
    d0 = done_cnt;
    e0 = err_cnt;
    ef = exp_frame(CMD_SET_LED);
    fork
      begin
        request(CMD_SET_LED);
        tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL led_ready_drop: got %b expected 0", tx_ready); end
      end
      device_xfer(1'b1, 11);
    join
    repeat (10) @(negedge clk);
    tests_run++; if (dev_ok !== 1'b1) begin tests_failed++; $display("FAIL led_device_wait: got %b expected 1", dev_ok); end
    tests_run++; if (dev_inh < INH) begin tests_failed++; $display("FAIL led_inhibit_len: got %0d expected >= %0d", dev_inh, INH); end
    tests_run++; if (dev_inh_d != DATA_LEAD_CYCLES) begin tests_failed++; $display("FAIL led_data_lead: got %0d expected %0d", dev_inh_d, DATA_LEAD_CYCLES); end
    tests_run++; if (dev_frame !== ef) begin tests_failed++; $display("FAIL led_frame: got %b expected %b", dev_frame, ef); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL led_done_count: got %0d expected 1", done_cnt - d0); end
    tests_run++; if (err_cnt - e0 != 0) begin tests_failed++; $display("FAIL led_err_count: got %0d expected 0", err_cnt - e0); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL led_ready_after: got %b expected 1", tx_ready); end
    tests_run++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin tests_failed++; $display("FAIL led_lines_released: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_parity();
    logic [7:0] fixed_b [3];
    logic       fixed_p [3];
    logic [7:0] b;
    int dn, er;
    fixed_b = '{8'h00, 8'hFF, 8'h01};
    fixed_p = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      b = (i < 3) ? fixed_b[i] : 8'($urandom_range(0, 255));
      run_xfer(b, 1'b1, dn, er);
      tests_run++; if (dev_ok !== 1'b1) begin tests_failed++; $display("FAIL parity_device_wait[%0d]: got %b expected 1", i, dev_ok); end
      tests_run++; if (dev_frame !== exp_frame(b)) begin tests_failed++; $display("FAIL parity_frame[%0h]: got %b expected %b", b, dev_frame, exp_frame(b)); end
      if (i < 3) begin
        tests_run++; if (dev_frame[9] !== fixed_p[i]) begin tests_failed++; $display("FAIL parity_bit[%0h]: got %b expected %b", b, dev_frame[9], fixed_p[i]); end
      end
      tests_run++; if (dn != 1 || er != 0) begin tests_failed++; $display("FAIL parity_end[%0h]: got done=%0d err=%0d expected done=1 err=0", b, dn, er); end
    end
  endtask

  task automatic test_no_ack();
    int dn, er;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    run_xfer(b, 1'b0, dn, er);
    tests_run++; if (dev_frame !== exp_frame(b)) begin tests_failed++; $display("FAIL noack_frame: got %b expected %b", dev_frame, exp_frame(b)); end
    tests_run++; if (er != 1) begin tests_failed++; $display("FAIL noack_err_count: got %0d expected 1", er); end
    tests_run++; if (dn != 0) begin tests_failed++; $display("FAIL noack_done_count: got %0d expected 0", dn); end
    tests_run++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin tests_failed++; $display("FAIL noack_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL noack_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int d0, e0, cyc, expected;
    bit got;
    logic [7:0] b;
    logic [10:0] ef;
    b = 8'($urandom_range(0, 255));
    ef = exp_frame(b);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      request(b);
      device_xfer(1'b1, 4);
    join
    tests_run++; if (dev_frame[3:0] !== ef[3:0]) begin tests_failed++; $display("FAIL timeout_first_bits: got %b expected %b", dev_frame[3:0], ef[3:0]); end
    // Fifth fall, then silence. Pin to err: FILT_LEN+1 samples to agree,
    // one edge to register the fall pulse, one edge for the sequencer to
    // take it, then the TMO-cycle timeout.
    expected = FL + 3 + TMO;
    @(negedge clk);
    dev_clk_low = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TMO + 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == HALF) dev_clk_low = 1'b0;
      if (err) got = 1'b1;
    end
    dev_clk_low = 1'b0;
    tests_run++; if (!got) begin tests_failed++; $display("FAIL timeout_seen: got none expected err within %0d cycles", TMO + 200); end
    tests_run++; if (cyc != expected) begin tests_failed++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, expected); end
    repeat (5) @(negedge clk);
    tests_run++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin tests_failed++; $display("FAIL timeout_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
    tests_run++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin tests_failed++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_valid_held();
    int d0, w, extra;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    fork
      begin
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        repeat (INH / 2) @(negedge clk);
        tx_data = ~b;
        w = 0;
        while (!done && w < 20000) begin
          @(negedge clk);
          w++;
        end
        tx_valid = 1'b0;
      end
      device_xfer(1'b1, 11);
    join
    extra = 0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) extra++;
    end
    tests_run++; if (dev_frame !== exp_frame(b)) begin tests_failed++; $display("FAIL held_frame: got %b expected %b", dev_frame, exp_frame(b)); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL held_done_count: got %0d expected 1", done_cnt - d0); end
    tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL held_second_xfer: got %0d inhibit cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int w, dn, er;
    logic pre_data_oe;
    logic [7:0] b;
    pre_data_oe = 1'b0;
    fork
      request(8'h00);
      begin
        w = 0;
        while (!ps2_clk_oe && w < 1000) begin @(negedge clk); w++; end
        w = 0;
        while (ps2_clk_oe && w < 4 * INH) begin @(negedge clk); w++; end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        pre_data_oe = ps2_data_oe;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (ps2_clk_oe !== 1'b0) begin tests_failed++; $display("FAIL midreset_clk_oe: got %b expected 0", ps2_clk_oe); end
        tests_run++; if (ps2_data_oe !== 1'b0) begin tests_failed++; $display("FAIL midreset_data_oe: got %b expected 0", ps2_data_oe); end
        tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 1", tx_ready); end
      end
    join
    tests_run++; if (pre_data_oe !== 1'b1) begin tests_failed++; $display("FAIL midreset_was_sending: got %b expected 1", pre_data_oe); end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    b = 8'($urandom_range(0, 255));
    run_xfer(b, 1'b1, dn, er);
    tests_run++; if (dev_inh < INH) begin tests_failed++; $display("FAIL postreset_inhibit: got %0d expected >= %0d", dev_inh, INH); end
    tests_run++; if (dev_frame !== exp_frame(b)) begin tests_failed++; $display("FAIL postreset_frame: got %b expected %b", dev_frame, exp_frame(b)); end
    tests_run++; if (dn != 1 || er != 0) begin tests_failed++; $display("FAIL postreset_end: got done=%0d err=%0d expected done=1 err=0", dn, er); end
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_parity();
    test_no_ack();
    test_timeout();
    test_valid_held();
    test_reset_mid();
    tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("FAIL done_err_overlap: got %0d expected 0", overlap_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
